// File: rtl/reg_file_param.sv
// Parametrised multi-port integer register file with a hardware clear
// sequencer and an optional same-cycle write-to-read bypass.
module reg_file_param #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRP      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = (NREGS > 2) ? $clog2(NREGS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_req,
    output logic                busy,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    output logic                wr_ack,
    input  logic [NRP*AW-1:0]   raddr,
    output logic [NRP*XLEN-1:0] rdata
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    // Address bound carries one extra bit so NREGS itself is representable.
    localparam logic [AW:0]   NR   = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    logic [0:0]      state;
    logic [AW-1:0]   clr_idx;
    logic [XLEN-1:0] mem [NREGS];

    logic wa_ok;
    logic wa_zero;

    assign busy    = (state == CLEAR);
    assign wa_ok   = ({1'b0, waddr} < NR);
    assign wa_zero = (ZERO_REG != 0) && (waddr == '0);
    assign wr_ack  = we & ~busy & wa_ok & ~wa_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            unique case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + AW'(1);
                    if (clr_idx == LAST) state <= IDLE;
                end
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The array itself has no reset; the sequencer zeroes it after reset.
    always_ff @(posedge clk) begin
        if (busy && rst_n) begin
            mem[clr_idx] <= '0;
        end else if (wr_ack) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < NRP; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;

        assign ra = raddr[i*AW +: AW];

        always_comb begin
            rd = '0;
            if (busy) begin
                rd = '0;
            end else if ({1'b0, ra} >= NR) begin
                rd = '0;
            end else if ((ZERO_REG != 0) && (ra == '0)) begin
                rd = '0;
            end else if ((BYPASS != 0) && wr_ack && (waddr == ra)) begin
                rd = wdata;
            end else begin
                rd = mem[ra];
            end
        end

        assign rdata[i*XLEN +: XLEN] = rd;
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: two configurations driven by shared stimulus
// and checked every cycle against an array-based reference model.
module tb_reg_file_param;

    logic        clk;
    logic        rst_n;
    logic        clr_req;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    logic        busy_a, ack_a;
    logic [9:0]  raddr_a;
    logic [63:0] rdata_a;
    logic [4:0]  ra_a [2];

    logic        busy_b, ack_b;
    logic [14:0] raddr_b;
    logic [95:0] rdata_b;
    logic [4:0]  ra_b [3];

    assign raddr_a = {ra_a[1], ra_a[0]};
    assign raddr_b = {ra_b[2], ra_b[1], ra_b[0]};

    reg_file_param #(
        .XLEN(32), .NREGS(32), .NRP(2), .ZERO_REG(1), .BYPASS(1)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_a),
        .we(we), .waddr(waddr), .wdata(wdata), .wr_ack(ack_a),
        .raddr(raddr_a), .rdata(rdata_a)
    );

    reg_file_param #(
        .XLEN(32), .NREGS(24), .NRP(3), .ZERO_REG(0), .BYPASS(0)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_b),
        .we(we), .waddr(waddr), .wdata(wdata), .wr_ack(ack_b),
        .raddr(raddr_b), .rdata(rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 = config A, index 1 = config B.
    int          n   [2] = '{32, 24};
    bit          zr  [2] = '{1'b1, 1'b0};
    bit          bp  [2] = '{1'b1, 1'b0};
    int          cnt [2];
    logic [31:0] mm  [2][32];

    int checks = 0;
    int errors = 0;
    logic seen_busy_a, seen_busy_b;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset(int k);
        cnt[k] = n[k];
        for (int r = 0; r < 32; r++) mm[k][r] = '0;
    endfunction

    function automatic bit exp_ack(int k);
        return we && (cnt[k] == 0) && (int'(waddr) < n[k])
            && !(zr[k] && waddr == 0);
    endfunction

    function automatic logic [31:0] exp_rd(int k, logic [4:0] ra);
        if (cnt[k] > 0) return '0;
        if (int'(ra) >= n[k]) return '0;
        if (zr[k] && ra == 0) return '0;
        if (bp[k] && exp_ack(k) && waddr == ra) return wdata;
        return mm[k][ra];
    endfunction

    function automatic void model_edge(int k);
        if (!rst_n) begin
            model_reset(k);
        end else if (cnt[k] > 0) begin
            cnt[k]--;
        end else begin
            if (exp_ack(k)) mm[k][waddr] = wdata;
            if (clr_req) model_reset(k);
        end
    endfunction

    // Inputs are set just after a falling edge; this checks, then
    // advances across one rising edge and returns at the next falling edge.
    task automatic tick();
        #1;
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
        end
        chk("busy_a", 32'(busy_a), 32'(cnt[0] > 0));
        chk("busy_b", 32'(busy_b), 32'(cnt[1] > 0));
        chk("ack_a", 32'(ack_a), 32'(exp_ack(0)));
        chk("ack_b", 32'(ack_b), 32'(exp_ack(1)));
        for (int p = 0; p < 2; p++)
            chk($sformatf("rd_a%0d[%0d]", p, ra_a[p]),
                rdata_a[p*32 +: 32], exp_rd(0, ra_a[p]));
        for (int p = 0; p < 3; p++)
            chk($sformatf("rd_b%0d[%0d]", p, ra_b[p]),
                rdata_b[p*32 +: 32], exp_rd(1, ra_b[p]));
        seen_busy_a = busy_a;
        seen_busy_b = busy_b;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
    endtask

    task automatic idle_in();
        clr_req = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
    endtask

    initial begin
        int ca, cb;
        rst_n = 1'b0;
        idle_in();
        for (int p = 0; p < 2; p++) ra_a[p] = '0;
        for (int p = 0; p < 3; p++) ra_b[p] = '0;
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        tick();
        tick();

        // Clear after reset release: A busy 32 cycles, B busy 24.
        rst_n = 1'b1;
        ca = 0; cb = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            ca += int'(seen_busy_a);
            cb += int'(seen_busy_b);
        end
        chk("rst_busy_len_a", 32'(ca), 32'd32);
        chk("rst_busy_len_b", 32'(cb), 32'd24);

        for (int r = 0; r < 32; r++) begin
            ra_a[0] = 5'(r); ra_a[1] = 5'(31 - r);
            ra_b[0] = 5'(r); ra_b[1] = 5'(r + 3); ra_b[2] = 5'(31 - r);
            tick();
        end

        // x5 write with same-cycle bypass on A.
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; ra_a[0] = 5'd5;
        #1;
        chk("x5_ack", 32'(ack_a), 32'd1);
        chk("x5_bypass", rdata_a[31:0], 32'hDEADBEEF);
        tick();
        idle_in();
        #1;
        chk("x5_read", rdata_a[31:0], 32'hDEADBEEF);
        tick();

        // B has no bypass: old value this cycle, new one the next.
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; ra_b[1] = 5'd7;
        #1;
        chk("x7_nobyp_old", rdata_b[63:32], 32'h0);
        tick();
        idle_in();
        #1;
        chk("x7_nobyp_new", rdata_b[63:32], 32'h12345678);
        tick();

        // x0: hardwired on A, ordinary on B.
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        #1;
        chk("x0_ack_a", 32'(ack_a), 32'd0);
        chk("x0_ack_b", 32'(ack_b), 32'd1);
        tick();
        idle_in();
        ra_a[0] = 5'd0; ra_b[0] = 5'd0;
        #1;
        chk("x0_rd_a", rdata_a[31:0], 32'h0);
        chk("x0_rd_b", rdata_b[31:0], 32'hFFFFFFFF);
        tick();

        // Clear request; writes during busy dropped; clr_req mid-clear ignored.
        we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
        tick();
        idle_in();
        clr_req = 1'b1;
        tick();
        ca = 0;
        for (int i = 0; i < 40; i++) begin
            idle_in();
            clr_req = (i == 10);
            if (i < 20) begin
                we = 1'b1; waddr = 5'd3; wdata = $urandom;
                #1;
                chk("busy_wr_ack", 32'(ack_a), 32'd0);
            end
            ra_a[0] = 5'd3;
            tick();
            ca += int'(seen_busy_a);
        end
        chk("clr_busy_len_a", 32'(ca), 32'd32);
        idle_in();
        #1;
        chk("x3_cleared", rdata_a[31:0], 32'h0);
        tick();

        // B: out-of-range address, three ports in parallel.
        we = 1'b1; waddr = 5'd30; wdata = 32'hCAFEF00D;
        #1;
        chk("b_oor_ack", 32'(ack_b), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            waddr = (i == 0) ? 5'd1 : (i == 1) ? 5'd2 : 5'd23;
            wdata = 32'h1000_0000 + 32'(waddr);
            tick();
        end
        idle_in();
        ra_b[0] = 5'd1; ra_b[1] = 5'd2; ra_b[2] = 5'd23;
        #1;
        chk("b_p0_x1", rdata_b[31:0], 32'h1000_0001);
        chk("b_p1_x2", rdata_b[63:32], 32'h1000_0002);
        chk("b_p2_x23", rdata_b[95:64], 32'h1000_0017);
        tick();
        ra_b[0] = 5'd30;
        tick();

        // Reset at clear cycle 10 restarts the sequence.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ca = 0; cb = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            ca += int'(seen_busy_a);
            cb += int'(seen_busy_b);
        end
        chk("rerst_busy_len_a", 32'(ca), 32'd32);
        chk("rerst_busy_len_b", 32'(cb), 32'd24);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_n   = ($urandom_range(0, 799) != 0);
            clr_req = ($urandom_range(0, 63) == 0);
            we      = ($urandom_range(0, 3) != 0);
            waddr   = 5'($urandom);
            wdata   = $urandom;
            for (int p = 0; p < 2; p++) ra_a[p] = 5'($urandom);
            for (int p = 0; p < 3; p++) ra_b[p] = 5'($urandom);
            if ($urandom_range(0, 2) == 0) ra_a[0] = waddr;
            if ($urandom_range(0, 2) == 0) ra_b[1] = waddr;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
Parametrised multi-read-port integer register file, the next generation of the processor's 32x32 register file. Configurable data width, register count and read-port count. Adds a hardware clear sequencer that zeroes the whole array after reset or on request. Adds an optional same-cycle write-to-read bypass. Writes commit on the rising edge of the core clock. Sits between decode (reads) and writeback (writes) in the single-cycle core.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (>=2, need not be a power of two)
NRP, 2, number of independent combinational read ports
ZERO_REG, 1, 1 = register 0 hardwired to zero (writes dropped, reads return 0)
BYPASS, 1, 1 = a read of the address being written this cycle returns wdata
(derived localparam AW = clog2(NREGS), minimum 1)

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
clr_req  input  1  one-cycle pulse requesting a full clear of the array
busy  output  1  high while the clear sequencer runs; reads/writes blocked
we  input  1  write enable
waddr  input  AW  write address
wdata  input  XLEN  write data
wr_ack  output  1  combinational: this cycle's write will commit at the next rising edge
raddr  input  NRP*AW  read addresses, port i at bits [i*AW +: AW]
rdata  output  NRP*XLEN  read data, port i at bits [i*XLEN +: XLEN]

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: FSM=CLEAR, clr_idx=0, busy=1, wr_ack=0, all rdata=0. Storage array is not reset directly.
- FSM states are IDLE and CLEAR.
- CLEAR state:
  - Each rising edge writes 0 to mem[clr_idx] and increments clr_idx.
  - On the edge that writes clr_idx=NREGS-1, the FSM goes to IDLE.
  - The full clear takes exactly NREGS cycles after rst_n deasserts; busy is low from the following cycle.
  - clr_req during CLEAR is ignored (no restart).
  - Reset asserted mid-clear restarts the sequence at index 0.
- IDLE state:
  - clr_req=1 moves the FSM to CLEAR with clr_idx=0; busy is high from the next cycle.
  - A write presented in the same cycle as clr_req still commits, then is cleared by the sequence.
- Write validity: wr_ack = we & ~busy & (waddr < NREGS) & ~(ZERO_REG & waddr==0).
  - When wr_ack=1, mem[waddr] <= wdata on the rising edge.
  - When wr_ack=0, the write is silently dropped.
- Read, per port i (purely combinational, evaluated in priority order):
  1. busy -> 0
  2. raddr_i >= NREGS -> 0
  3. ZERO_REG & raddr_i==0 -> 0
  4. BYPASS & wr_ack & waddr==raddr_i -> wdata
  5. otherwise mem[raddr_i]
- With BYPASS=0, a read of the register being written returns the old value this cycle and the new value from the next cycle.
- All read ports are independent. Any number of ports may read the same address.
- With ZERO_REG=0, register 0 behaves like any other register.

Test Plan:
- Reset, then release rst_n: busy high for exactly 32 cycles, then low. All 32 registers on both ports read 0x00000000.
- After clear, we=1, waddr=5, wdata=0xDEADBEEF, one cycle: wr_ack=1. Next cycle raddr0=5 -> rdata0=0xDEADBEEF. Same cycle (BYPASS=1): rdata0=0xDEADBEEF.
- Bypass off (BYPASS=0): write x7=0x12345678 while raddr1=7 -> rdata1 shows the old value that cycle and 0x12345678 the next cycle.
- we=1, waddr=0, wdata=0xFFFFFFFF: wr_ack=0, read x0 = 0. Same test with ZERO_REG=0: wr_ack=1, x0 reads 0xFFFFFFFF.
- Write x3=0xA5A5A5A5, pulse clr_req: busy high for 32 cycles, then x3=0. A write with we=1 during busy gives wr_ack=0 and is dropped. clr_req pulsed mid-clear does not extend busy.
- NREGS=24, NRP=3: write to addr 30 gives wr_ack=0. Read addr 30 = 0. Three ports reading x1, x2, x23 return their written values simultaneously. Reset asserted at clear cycle 10 restarts the 24-cycle sequence.
